shreg_fifo: RTL and testbench

//  Synchronous FIFO built on a shift-register storage chain.
//  - Write side shifts every accepted word into stage 0 of a per-bit delay line.
//  - Read side selects the oldest word through a variable tap at index count-1.
//  - Storage stages carry no reset and no enable other than push, so the chain

---
 rtl/shreg_fifo.sv | 67 ++++++
 tb/tb_shreg_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/shreg_fifo.sv
// Synchronous FIFO whose storage is a push-enabled shift chain read through a
// variable tap at count-1; only the occupancy counter is reset.
module shreg_fifo #(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 130,
  localparam int unsigned CW = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rn,
  input  logic [width-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [width-1:0] q,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;

  logic [depth-1:0][width-1:0] sr;
  logic [CW-1:0]               count_q, count_d;
  logic [AW-1:0]               tap;
  logic                        push, pop;

  // Handshakes depend only on the registered count and rn, never on the peer's request.
  assign i_ready = rn & (count_q != CW'(depth));
  assign o_valid = rn & (count_q != '0);
  assign push    = i_valid & i_ready;
  assign pop     = o_ready & o_valid;
  assign count   = count_q;

  // No reset and no enable other than push keeps the chain SRL-friendly.
  always_ff @(posedge clk) begin
    if (push) begin
      sr <= {sr[depth-2:0], i};
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Oldest word sits at count-1; when empty the tap parks on stage 0.
  always_comb begin
    tap = '0;
    if (count_q != '0) begin
      tap = AW'(count_q - CW'(1));
    end
  end

  assign q = sr[tap];

endmodule

// File: tb/tb_shreg_fifo.sv
// Directed bench for shreg_fifo: a queue model predicts q/count/handshakes each cycle.
module tb_shreg_fifo;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 130;
  localparam int unsigned CW    = $clog2(Depth + 1);

  logic             clk = 1'b0;
  logic             rn = 1'b0;
  logic [Width-1:0] i = '0;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [Width-1:0] q;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [Width-1:0] sb[$];

  always #5 clk = ~clk;

  shreg_fifo #(
    .width(Width),
    .depth(Depth)
  ) dut (
    .clk    (clk),
    .rn     (rn),
    .i      (i),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .q      (q),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .count  (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance model and clock.
  task automatic step(input logic r, input logic iv, input logic [Width-1:0] d,
                      input logic ordy);
    logic do_push, do_pop;
    rn      = r;
    i_valid = iv;
    i       = d;
    o_ready = ordy;
    #1;
    chk("count", 32'(count), 32'(sb.size()));
    chk("o_valid", 32'(o_valid), 32'(r && sb.size() != 0));
    chk("i_ready", 32'(i_ready), 32'(r && sb.size() != Depth));
    if (r && sb.size() != 0) chk("q_oldest", 32'(q), 32'(sb[0]));
    do_push = r && iv && sb.size() != Depth;
    do_pop  = r && ordy && sb.size() != 0;
    @(posedge clk);
    if (!r) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(d);
    end
    #1;
  endtask

  initial begin
    // 1. reset held two cycles
    rn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rel_i_ready", 32'(i_ready), 32'd1);

    // pop on empty is ignored
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("empty_pop_count", 32'(count), 32'd0);

    // 2. three pushes, then drain
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("lat_q", 32'(q), 32'hA5);
    chk("lat_o_valid", 32'(o_valid), 32'd1);
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    step(1'b1, 1'b1, 8'hF0, 1'b0);
    chk("three_count", 32'(count), 32'd3);
    chk("three_q", 32'(q), 32'hA5);
    repeat (4) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("drain_o_valid", 32'(o_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // 3. fill to depth, push while full (with and without pop), drain
    for (int k = 0; k < int'(Depth); k++) step(1'b1, 1'b1, 8'(k), 1'b0);
    chk("full_count", 32'(count), 32'(Depth));
    chk("full_i_ready", 32'(i_ready), 32'd0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("full_ign_count", 32'(count), 32'(Depth));
    chk("full_ign_q", 32'(q), 32'h00);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("full_pop_count", 32'(count), 32'(Depth - 1));
    chk("full_pop_q", 32'(q), 32'h01);
    for (int k = 1; k < int'(Depth); k++) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("full_drain_count", 32'(count), 32'd0);

    // 4. simultaneous push and pop at count=5
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 8'(8'h10 + k), 1'b0);
    step(1'b1, 1'b1, 8'h20, 1'b1);
    chk("pp_count", 32'(count), 32'd5);
    chk("pp_q", 32'(q), 32'h11);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("pp_drain_count", 32'(count), 32'd0);

    // 5. reset mid-operation with i_valid high
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 8'(8'h60 + k), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd7);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
    step(1'b1, 1'b1, 8'h42, 1'b0);
    chk("post_rst_q", 32'(q), 32'h42);
    chk("post_rst_count", 32'(count), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
